// File: rtl/spi_byte_rx.sv
// Mode-0 SPI slave byte engine: synchronizes the SPI pins into clk, deserializes
// MOSI into bytes with a one-cycle done strobe, and shifts a staged byte out on MISO.
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_in,
    input  logic       cs_n_in,
    input  logic       mosi_in,
    output logic       miso_out,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic [7:0] rx_data,
    output logic [3:0] cmd,
    output logic       done,
    output logic       frame_active,
    output logic [7:0] byte_cnt
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic       sclk_d_q, sclk_d_d;
    logic       cs_d_q, cs_d_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    // Bits still to be sent after the one currently on miso_out.
    logic [6:0] tx_shift_q, tx_shift_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic       hold_valid_q, hold_valid_d;
    logic       done_q, done_d;
    logic       miso_q, miso_d;
    logic       active_q, active_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;

    logic       sclk_s, cs_s, mosi_s;
    logic       rise, fall, cs_start, consume;
    logic [7:0] tx_next;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // active_q is set only by a clean high-to-low cs_s edge, so after a reset
    // taken mid-frame the remainder of that frame is ignored.
    assign cs_start = ~cs_s & cs_d_q;
    assign rise     = sclk_s & ~sclk_d_q & ~cs_s & active_q;
    assign fall     = ~sclk_s & sclk_d_q & ~cs_s & active_q;
    assign tx_next  = hold_valid_q ? tx_hold_q : 8'h00;

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
        sclk_d_d     = sclk_s;
        cs_d_d       = cs_s;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        rx_data_d    = rx_data_q;
        tx_shift_d   = tx_shift_q;
        tx_hold_d    = tx_hold_q;
        hold_valid_d = hold_valid_q;
        done_d       = 1'b0;
        miso_d       = miso_q;
        active_d     = active_q;
        byte_cnt_d   = byte_cnt_q;
        consume      = 1'b0;

        if (cs_s) begin
            active_d  = 1'b0;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
        end else if (cs_start) begin
            active_d   = 1'b1;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 8'd0;
            rx_shift_d = 7'd0;
            miso_d     = tx_next[7];
            tx_shift_d = tx_next[6:0];
            consume    = 1'b1;
        end else if (rise) begin
            rx_shift_d = {rx_shift_q[5:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                rx_data_d = {rx_shift_q, mosi_s};
                done_d    = 1'b1;
                if (byte_cnt_q != 8'hFF) begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                end
            end
        end else if (fall) begin
            if (bit_cnt_q == 3'd0) begin
                miso_d     = tx_next[7];
                tx_shift_d = tx_next[6:0];
                consume    = 1'b1;
            end else begin
                miso_d     = tx_shift_q[6];
                tx_shift_d = {tx_shift_q[5:0], 1'b0};
            end
        end

        // tx_load is a bare strobe with no back-pressure: a load in the same
        // cycle as a consume wins, so the freshly staged byte is never lost.
        if (consume) begin
            hold_valid_d = 1'b0;
        end
        if (tx_load) begin
            tx_hold_d    = tx_data;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q  <= '0;
            cs_sync_q    <= '0;
            mosi_sync_q  <= '0;
            sclk_d_q     <= 1'b0;
            cs_d_q       <= 1'b0;
            bit_cnt_q    <= 3'd0;
            rx_shift_q   <= 7'd0;
            rx_data_q    <= 8'h00;
            tx_shift_q   <= 7'd0;
            tx_hold_q    <= 8'h00;
            hold_valid_q <= 1'b0;
            done_q       <= 1'b0;
            miso_q       <= 1'b0;
            active_q     <= 1'b0;
            byte_cnt_q   <= 8'd0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_d_q     <= sclk_d_d;
            cs_d_q       <= cs_d_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            rx_data_q    <= rx_data_d;
            tx_shift_q   <= tx_shift_d;
            tx_hold_q    <= tx_hold_d;
            hold_valid_q <= hold_valid_d;
            done_q       <= done_d;
            miso_q       <= miso_d;
            active_q     <= active_d;
            byte_cnt_q   <= byte_cnt_d;
        end
    end

    assign miso_out     = miso_q;
    assign miso_oe      = active_q;
    assign frame_active = active_q;
    assign rx_data      = rx_data_q;
    assign cmd          = rx_data_q[7:4];
    assign done         = done_q;
    assign byte_cnt     = byte_cnt_q;

endmodule

// File: tb/tb_spi_byte_rx.sv
// Directed bench for spi_byte_rx: drives SPI mode-0 frames at clk/8 and checks
// received bytes, done pulses, byte counting, MISO bits, aborts and reset.
module tb_spi_byte_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk_in;
    logic       cs_n_in;
    logic       mosi_in;
    logic       miso_out;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] rx_data;
    logic [3:0] cmd;
    logic       done;
    logic       frame_active;
    logic [7:0] byte_cnt;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int consec_cnt = 0;
    int base = 0;
    int lat = 0;
    logic       done_prev = 1'b0;
    logic [7:0] mb;
    logic [7:0] b;

    spi_byte_rx #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk_in(sclk_in), .cs_n_in(cs_n_in), .mosi_in(mosi_in),
        .miso_out(miso_out), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
        .rx_data(rx_data), .cmd(cmd), .done(done), .frame_active(frame_active),
        .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (done_prev) consec_cnt++;
        end
        done_prev = done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sends the top nbits of m MSB first (SCLK half period = 4 clk), samples
    // MISO at each rising SCLK, and reports how many clk after the last rise
    // done appeared. Optionally strobes tx_load right after done.
    task automatic spi_bits(input logic [7:0] m, input int nbits, input logic load_en,
                            input logic [7:0] load_val, output logic [7:0] miso_b,
                            output int dlat);
        miso_b = 8'h00;
        dlat = 0;
        for (int i = 0; i < nbits; i++) begin
            mosi_in = m[7-i];
            repeat (4) @(negedge clk);
            sclk_in = 1'b1;
            miso_b[7-i] = miso_out;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                tx_load = 1'b0;
                if (done && dlat == 0) begin
                    dlat = k;
                    if (load_en) begin
                        tx_load = 1'b1;
                        tx_data = load_val;
                    end
                end
            end
            tx_load = 1'b0;
            sclk_in = 1'b0;
        end
    endtask

    task automatic cs_fall();
        cs_n_in = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_rise();
        repeat (4) @(negedge clk);
        cs_n_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; sclk_in = 1'b0; cs_n_in = 1'b1; mosi_in = 1'b0;
        tx_load = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_miso_out", miso_out, 0);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_cmd", cmd, 4'h0);
        chk("rst_done", done, 0);
        chk("rst_frame_active", frame_active, 0);
        chk("rst_byte_cnt", byte_cnt, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // SCLK activity while CS is high must be ignored.
        base = done_cnt;
        for (int i = 0; i < 16; i++) begin
            mosi_in = i[0];
            sclk_in = 1'b1;
            repeat (4) @(negedge clk);
            sclk_in = 1'b0;
            repeat (4) @(negedge clk);
        end
        chk("csh_done_cnt", done_cnt - base, 0);
        chk("csh_byte_cnt", byte_cnt, 0);
        chk("csh_miso_oe", miso_oe, 0);
        chk("csh_frame_active", frame_active, 0);

        // Single byte with preloaded response.
        tx_data = 8'hA5; tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        cs_fall();
        chk("b1_frame_active", frame_active, 1);
        chk("b1_miso_oe", miso_oe, 1);
        chk("b1_first_miso", miso_out, 1);
        base = done_cnt;
        spi_bits(8'h3C, 8, 1'b0, 8'h00, mb, lat);
        repeat (4) @(negedge clk);
        chk("b1_done_cnt", done_cnt - base, 1);
        chk("b1_done_latency", lat, 3);
        chk("b1_rx_data", rx_data, 8'h3C);
        chk("b1_cmd", cmd, 4'h3);
        chk("b1_byte_cnt", byte_cnt, 1);
        chk("b1_miso_byte", mb, 8'hA5);
        cs_rise();
        chk("b1_end_miso_oe", miso_oe, 0);
        chk("b1_end_miso_out", miso_out, 0);
        chk("b1_end_frame_active", frame_active, 0);
        chk("b1_end_rx_data", rx_data, 8'h3C);

        // Two-byte frame, response staged right after the first done.
        cs_fall();
        base = done_cnt;
        spi_bits(8'h1F, 8, 1'b1, 8'h81, mb, lat);
        chk("b2a_miso_byte", mb, 8'h00);
        chk("b2a_rx_data", rx_data, 8'h1F);
        chk("b2a_cmd", cmd, 4'h1);
        chk("b2a_byte_cnt", byte_cnt, 1);
        spi_bits(8'hE2, 8, 1'b0, 8'h00, mb, lat);
        chk("b2b_miso_byte", mb, 8'h81);
        chk("b2b_rx_data", rx_data, 8'hE2);
        chk("b2b_cmd", cmd, 4'hE);
        chk("b2b_byte_cnt", byte_cnt, 2);
        chk("b2_done_cnt", done_cnt - base, 2);
        cs_rise();

        // CS abort after 5 bits, then a clean frame.
        cs_fall();
        base = done_cnt;
        spi_bits(8'hC3, 5, 1'b0, 8'h00, mb, lat);
        cs_rise();
        chk("abort_done_cnt", done_cnt - base, 0);
        chk("abort_rx_data", rx_data, 8'hE2);
        chk("abort_miso_oe", miso_oe, 0);
        chk("abort_frame_active", frame_active, 0);
        cs_fall();
        spi_bits(8'h77, 8, 1'b0, 8'h00, mb, lat);
        chk("after_abort_rx_data", rx_data, 8'h77);
        chk("after_abort_cmd", cmd, 4'h7);
        chk("after_abort_byte_cnt", byte_cnt, 1);
        chk("after_abort_done_cnt", done_cnt - base, 1);
        cs_rise();

        // Reset mid-byte with CS held low: the rest of that frame is ignored.
        cs_fall();
        base = done_cnt;
        spi_bits(8'hAA, 4, 1'b0, 8'h00, mb, lat);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_miso_out", miso_out, 0);
        chk("mrst_miso_oe", miso_oe, 0);
        chk("mrst_rx_data", rx_data, 8'h00);
        chk("mrst_cmd", cmd, 4'h0);
        chk("mrst_done", done, 0);
        chk("mrst_frame_active", frame_active, 0);
        chk("mrst_byte_cnt", byte_cnt, 0);
        spi_bits(8'hAA, 4, 1'b0, 8'h00, mb, lat);
        spi_bits(8'h55, 8, 1'b0, 8'h00, mb, lat);
        chk("mrst_ignored_done_cnt", done_cnt - base, 0);
        chk("mrst_ignored_byte_cnt", byte_cnt, 0);
        chk("mrst_ignored_rx_data", rx_data, 8'h00);
        cs_rise();
        cs_fall();
        spi_bits(8'h5A, 8, 1'b0, 8'h00, mb, lat);
        chk("mrst_new_done_cnt", done_cnt - base, 1);
        chk("mrst_new_rx_data", rx_data, 8'h5A);
        chk("mrst_new_byte_cnt", byte_cnt, 1);
        cs_rise();

        // 260 bytes in one frame: byte_cnt saturates, done keeps pulsing.
        cs_fall();
        base = done_cnt;
        b = 8'h00;
        for (int i = 0; i < 260; i++) begin
            b = 8'(i) ^ 8'h5A;
            spi_bits(b, 8, 1'b0, 8'h00, mb, lat);
            if (i == 253) chk("sat_byte_cnt_254", byte_cnt, 254);
            if (i == 254) chk("sat_byte_cnt_255", byte_cnt, 255);
        end
        chk("sat_byte_cnt_final", byte_cnt, 255);
        chk("sat_done_cnt", done_cnt - base, 260);
        chk("sat_rx_data", rx_data, b);
        chk("sat_done_latency", lat, 3);
        chk("sat_miso_byte", mb, 8'h00);
        cs_rise();

        chk("no_consecutive_done", consec_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
